// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-type encodings, FSM states and
// legality/alignment helpers used by lsu_hs and lsu_align.
package lsu_pkg;

    localparam logic [2:0] RW_B  = 3'd0;
    localparam logic [2:0] RW_H  = 3'd1;
    localparam logic [2:0] RW_W  = 3'd2;
    localparam logic [2:0] RW_D  = 3'd3;
    localparam logic [2:0] RW_BU = 3'd4;
    localparam logic [2:0] RW_HU = 3'd5;
    localparam logic [2:0] RW_WU = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Type 7, unsigned stores and 64-bit-only types on a 32-bit datapath are rejected.
    function automatic logic is_legal(input logic [2:0] rw_type, input logic we, input int xlen);
        logic ok;
        ok = 1'b1;
        if (rw_type == 3'd7) begin
            ok = 1'b0;
        end else if (we && (rw_type >= RW_BU)) begin
            ok = 1'b0;
        end else if ((xlen == 32) && ((rw_type == RW_D) || (rw_type == RW_WU))) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    function automatic logic is_aligned(input logic [2:0] rw_type, input logic [2:0] addr_lo);
        logic ok;
        ok = 1'b1;
        case (rw_type)
            RW_H, RW_HU: ok = (addr_lo[0] == 1'b0);
            RW_W, RW_WU: ok = (addr_lo[1:0] == 2'b00);
            RW_D:        ok = (addr_lo == 3'b000);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store byte enables and data placement,
// and load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]                  i_st_type,
    input  logic [$clog2(XLEN/8)-1:0]   i_st_off,
    input  logic [XLEN-1:0]             i_st_wdata,
    output logic [XLEN/8-1:0]           o_be,
    output logic [XLEN-1:0]             o_wdata,
    input  logic [2:0]                  i_ld_type,
    input  logic [$clog2(XLEN/8)-1:0]   i_ld_off,
    input  logic [XLEN-1:0]             i_ld_rdata,
    output logic [XLEN-1:0]             o_ld_data
);

    localparam int NB = XLEN / 8;

    logic [NB-1:0]   w_mask;
    logic [XLEN-1:0] w_shift;

    // Lane mask sized by access width, then moved up to the addressed lane
    always_comb begin
        w_mask = {NB{1'b0}};
        case (i_st_type)
            RW_B, RW_BU: w_mask = NB'(1);
            RW_H, RW_HU: w_mask = NB'(3);
            RW_W, RW_WU: w_mask = NB'(15);
            RW_D:        w_mask = {NB{1'b1}};
            default:     w_mask = {NB{1'b0}};
        endcase
    end

    assign o_be    = w_mask << i_st_off;
    assign o_wdata = i_st_wdata << {i_st_off, 3'b000};
    assign w_shift = i_ld_rdata >> {i_ld_off, 3'b000};

    // Load result: low bytes of the shifted beat, extended per access type
    always_comb begin
        o_ld_data = {XLEN{1'b0}};
        case (i_ld_type)
            RW_B:    o_ld_data = XLEN'($signed(w_shift[7:0]));
            RW_H:    o_ld_data = XLEN'($signed(w_shift[15:0]));
            RW_W:    o_ld_data = XLEN'($signed(w_shift[31:0]));
            RW_BU:   o_ld_data = XLEN'(w_shift[7:0]);
            RW_HU:   o_ld_data = XLEN'(w_shift[15:0]);
            RW_WU:   o_ld_data = XLEN'(w_shift[31:0]);
            RW_D:    o_ld_data = w_shift;
            default: o_ld_data = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/lsu_hs.sv
// Load/store unit with request/grant/response memory handshake and core stall.
// Optional bus timeout is built when LSU_TIMEOUT_EN is defined.
module lsu_hs
    import lsu_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_rw_type,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 resp_err,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [XLEN/8-1:0]    mem_be,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata,
    input  logic                 mem_err
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    lsu_state_e         r_state;
    logic               r_req_ready;
    logic               r_we;
    logic [2:0]         r_type;
    logic [OFFW-1:0]    r_off;
    logic               r_resp_valid;
    logic               r_resp_err;
    logic [XLEN-1:0]    r_resp_rdata;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [NB-1:0]      r_mem_be;
    logic [XLEN-1:0]    r_mem_wdata;

    logic               w_ok;
    logic               w_timeout;
    logic [ADDR_W-1:0]  w_addr_aligned;
    logic [NB-1:0]      w_be;
    logic [XLEN-1:0]    w_wdata;
    logic [XLEN-1:0]    w_ld_data;

    assign w_ok           = is_legal(req_rw_type, req_we, XLEN) && is_aligned(req_rw_type, req_addr[2:0]);
    assign w_addr_aligned = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};

    // Store side works on the incoming request so mem_* can be registered at accept
    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_st_type  (req_rw_type),
        .i_st_off   (req_addr[OFFW-1:0]),
        .i_st_wdata (req_wdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .i_ld_type  (r_type),
        .i_ld_off   (r_off),
        .i_ld_rdata (mem_rdata),
        .o_ld_data  (w_ld_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // Cycles spent with a bus transaction outstanding; zero whenever none is
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= {CNT_W{1'b0}};
        end
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Access sequencer; every output is a register updated on state transitions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_we         <= 1'b0;
            r_type       <= 3'd0;
            r_off        <= {OFFW{1'b0}};
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= {XLEN{1'b0}};
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= {ADDR_W{1'b0}};
            r_mem_be     <= {NB{1'b0}};
            r_mem_wdata  <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_we        <= req_we;
                        r_type      <= req_rw_type;
                        r_off       <= req_addr[OFFW-1:0];
                        if (w_ok) begin
                            r_state     <= ST_REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= req_we;
                            r_mem_addr  <= w_addr_aligned;
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                        end else begin
                            // Rejected access answers immediately without touching the bus
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= {XLEN{1'b0}};
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        r_state   <= ST_WAIT;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_mem_be  <= {NB{1'b0}};
                    end else if (w_timeout) begin
                        r_state      <= ST_RESP;
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_mem_be     <= {NB{1'b0}};
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= {XLEN{1'b0}};
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= mem_err;
                        r_resp_rdata <= (mem_err || r_we) ? {XLEN{1'b0}} : w_ld_data;
                    end else if (w_timeout) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= {XLEN{1'b0}};
                    end
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= {XLEN{1'b0}};
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_mem_req    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;

endmodule
